graph_bfs_path: RTL and testbench
=================================

GRAPH_BFS_PATH -- requirements
Module: graph_bfs_path

Interface
REQ-001 SHALL have parameter NODES, default 64, meaning graph node count; NID_W = clog2(NODES).
REQ-002 SHALL have parameter EDGES, default 1034, meaning edge-table depth; EIDX_W = clog2(EDGES).
REQ-003 SHALL have parameter MAX_LEVEL, default 10, meaning maximum path length in edges; LVL_W = clog2(MAX_LEVEL+1).
REQ-004 CLK  in  1  clock; all logic on rising edge.
REQ-005 RST_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  one-cycle request pulse; sampled only in IDLE.
REQ-007 start_node, end_node  in  NID_W  search endpoints, captured on start.
REQ-008 edge_mask  in  EDGES  1 = edge unusable; captured on start.
REQ-009 edge_rd / edge_addr  out  1 / EIDX_W  edge-table read strobe and index.
REQ-010 edge_a, edge_b  in  NID_W each  endpoints of the edge read one cycle earlier.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 path_valid / path_ready  out / in  1 each  path-stream handshake.
REQ-013 path_edge / path_node  out  EIDX_W / NID_W  edge index and its far-side node, ordered end-to-start.
REQ-014 done / found / path_len  out  1 / 1 / LVL_W  one-cycle completion pulse, success flag, edge count.

Function
REQ-015 SHALL implement states IDLE, INIT, SWEEP, EVAL, BACK, FIN.
REQ-016 IDLE->INIT on start; start while busy SHALL be ignored.
REQ-017 INIT (1 cycle): visited V = one-hot(start_node), snapshot S = V, level = 0, mask latched, parent valid bits cleared; if start_node == end_node -> FIN with found=1, path_len=0, no stream beats.
REQ-018 SWEEP: edge_addr steps 0..EDGES-1 with edge_rd=1; edge data is used one cycle later; a sweep lasts EDGES+1 cycles.
REQ-019 An edge i SHALL expand iff mask[i]=0, both endpoints < NODES, exactly one endpoint is in S, and the other endpoint u is not in V.
REQ-020 On expansion: set V[u], parent_edge[u]=i, parent_node[u]=the endpoint in S; the first (lowest-index) discovery wins.
REQ-021 Self-loops and out-of-range endpoints SHALL never expand.
REQ-022 EVAL (1 cycle), in priority order:
  - V[end_node] set -> BACK with path_len = level+1.
  - no node added this sweep -> FIN with found=0.
  - level+1 == MAX_LEVEL -> FIN with found=0.
  - otherwise level++, S = V, return to SWEEP.
REQ-023 BACK: cur starts at end_node; path_valid=1 drives path_edge=parent_edge[cur] and path_node=cur.
REQ-024 On each path_valid&&path_ready: cur = parent_node[cur]; when the new cur == start_node -> FIN.
REQ-025 path outputs SHALL hold stable while path_valid&&!path_ready; exactly path_len beats are emitted.
REQ-026 FIN: done=1 for one cycle, found/path_len valid that cycle and held until the next start; then IDLE.
REQ-027 Backward walk needs no edge-table reads: edge_rd=0 outside SWEEP.

Reset
REQ-028 While RST_n=0: state=IDLE, busy=0, edge_rd=0, edge_addr=0, path_valid=0, path_edge=0, path_node=0, done=0, found=0, path_len=0, V=S=0.
REQ-029 Reset asserted mid-operation SHALL abort immediately with no done pulse; the next start begins a fresh search.

Structure
REQ-030 Package graph_pkg SHALL hold the state enum and the width-derivation functions/constants.
REQ-031 Parent storage SHALL be one sub-module graph_parent_ram: NODES x (EIDX_W+NID_W), 1 write port, 1 async read port, per-entry valid cleared in INIT.

Verification (NODES=8, EDGES=16, MAX_LEVEL=4; unlisted edges (7,7))
REQ-032 Chain e0(0,1) e1(1,2) e2(2,3), start 0 end 3 -> found=1, path_len=3; beats (e2,n3), (e1,n2), (e0,n1).
REQ-033 Previous table plus e3(3,0) -> path_len=1, single beat (e3,n3); also mask bit3=1 -> path_len=3.
REQ-034 Only e0(0,1), start 0 end 5 -> found=0 after 2 sweeps; done 2*(EDGES+2)+1 cycles after start.
REQ-035 Chain 0-1-2-3-4-5, start 0 end 5 -> found=0 (MAX_LEVEL exceeded); start=end=6 -> done, found=1, path_len=0, no beats.
REQ-036 Case REQ-032 with path_ready toggling 1-0-0-1 -> beats unchanged while stalled; RST_n low mid-SWEEP -> busy=0 next cycle, no done pulse.

Source files
------------

// File: rtl/graph_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : graph_pkg
//  Purpose  : Shared FSM state encoding and width-derivation helpers for the
//             breadth-first path search block.
//  Revision : 1.0  initial release
// ============================================================================
package graph_pkg;

    // Search controller states; values fixed so traces stay readable.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_SWEEP = 3'd2,
        ST_EVAL  = 3'd3,
        ST_BACK  = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    // Bits needed to index n items; never less than one so ports stay legal.
    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/graph_parent_ram.sv
`default_nettype none
// ============================================================================
//  Module   : graph_parent_ram
//  Purpose  : Per-node BFS parent storage (edge index + parent node) with one
//             write port, one asynchronous read port and per-entry valid bits
//             that can be cleared in a single cycle.
//  Revision : 1.0  initial release
// ============================================================================
module graph_parent_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 17
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    output logic          rvalid
);

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] valid;

    // Data array: plain write port, contents are qualified by the valid bits.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Valid bits: wiped on reset or at the start of every search.
    always_ff @(posedge CLK) begin
        if (!RST_n || clr) begin
            valid <= '0;
        end else if (we) begin
            valid[waddr] <= 1'b1;
        end
    end

    assign rdata  = mem[raddr];
    assign rvalid = valid[raddr];

endmodule
`default_nettype wire

// File: rtl/graph_bfs_path.sv
`default_nettype none
// ============================================================================
//  Module   : graph_bfs_path
//  Purpose  : Level-synchronous BFS over an external edge table, followed by a
//             backward walk that streams the found path end-to-start.
//  Revision : 1.0  initial release
// ============================================================================
module graph_bfs_path
    import graph_pkg::*;
#(
    parameter  int NODES     = 64,
    parameter  int EDGES     = 1034,
    parameter  int MAX_LEVEL = 10,
    localparam int NID_W     = bits_for(NODES),
    localparam int EIDX_W    = bits_for(EDGES),
    localparam int LVL_W     = bits_for(MAX_LEVEL + 1)
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              start,
    input  logic [NID_W-1:0]  start_node,
    input  logic [NID_W-1:0]  end_node,
    input  logic [EDGES-1:0]  edge_mask,
    output logic              edge_rd,
    output logic [EIDX_W-1:0] edge_addr,
    input  logic [NID_W-1:0]  edge_a,
    input  logic [NID_W-1:0]  edge_b,
    output logic              busy,
    output logic              path_valid,
    input  logic              path_ready,
    output logic [EIDX_W-1:0] path_edge,
    output logic [NID_W-1:0]  path_node,
    output logic              done,
    output logic              found,
    output logic [LVL_W-1:0]  path_len
);

    localparam int             PAR_W    = EIDX_W + NID_W;
    localparam logic [NID_W:0]  NODE_LIM = (NID_W + 1)'(NODES);
    localparam logic [EIDX_W:0] CNT_LAST = (EIDX_W + 1)'(EDGES);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(MAX_LEVEL);
    localparam logic [NODES-1:0] ONE_NODE = NODES'(1);

    state_t              state;
    logic [NID_W-1:0]    start_q;
    logic [NID_W-1:0]    end_q;
    logic [EDGES-1:0]    mask_q;
    logic [NODES-1:0]    visited;
    logic [NODES-1:0]    snap;
    logic [LVL_W-1:0]    level;
    logic [EIDX_W:0]     cnt;
    logic                rd_d;
    logic [EIDX_W-1:0]   idx_d;
    logic                added;
    logic [NID_W-1:0]    cur;

    logic                a_ok;
    logic                b_ok;
    logic                a_in_s;
    logic                b_in_s;
    logic                expand;
    logic [NID_W-1:0]    far_node;
    logic [NID_W-1:0]    near_node;
    logic [LVL_W-1:0]    lvl_nx;
    logic [PAR_W-1:0]    par_data;
    logic                par_vld;
    logic [EIDX_W-1:0]   par_edge;
    logic [NID_W-1:0]    par_node;

    assign lvl_nx   = level + 1'b1;
    assign par_edge = par_data[PAR_W-1:NID_W];
    assign par_node = par_data[NID_W-1:0];

    // Edge-table read sequencing: one index per SWEEP cycle, final cycle drains.
    always_comb begin
        edge_rd   = (state == ST_SWEEP) && (cnt < CNT_LAST);
        edge_addr = edge_rd ? cnt[EIDX_W-1:0] : '0;
    end

    // Status and path-stream outputs decoded from state and parent lookup.
    always_comb begin
        busy       = (state != ST_IDLE);
        done       = (state == ST_FIN);
        path_valid = (state == ST_BACK) && par_vld;
        path_edge  = path_valid ? par_edge : '0;
        path_node  = path_valid ? cur : '0;
    end

    // Remember which edge index the returning table data belongs to.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            rd_d  <= 1'b0;
            idx_d <= '0;
        end else begin
            rd_d  <= edge_rd;
            idx_d <= edge_addr;
        end
    end

    // Expansion test: exactly one endpoint on the frontier, other one unseen.
    always_comb begin
        a_ok      = ({1'b0, edge_a} < NODE_LIM);
        b_ok      = ({1'b0, edge_b} < NODE_LIM);
        a_in_s    = a_ok && snap[edge_a];
        b_in_s    = b_ok && snap[edge_b];
        expand    = 1'b0;
        far_node  = '0;
        near_node = '0;
        if ((state == ST_SWEEP) && rd_d && !mask_q[idx_d] && a_ok && b_ok) begin
            if (a_in_s && !b_in_s && !visited[edge_b]) begin
                expand    = 1'b1;
                far_node  = edge_b;
                near_node = edge_a;
            end else if (b_in_s && !a_in_s && !visited[edge_a]) begin
                expand    = 1'b1;
                far_node  = edge_a;
                near_node = edge_b;
            end
        end
    end

    graph_parent_ram #(
        .DEPTH (NODES),
        .AW    (NID_W),
        .DW    (PAR_W)
    ) u_parent (
        .CLK    (CLK),
        .RST_n  (RST_n),
        .clr    (state == ST_INIT),
        .we     (expand),
        .waddr  (far_node),
        .wdata  ({idx_d, near_node}),
        .raddr  (cur),
        .rdata  (par_data),
        .rvalid (par_vld)
    );

    // Search controller: frontier sweeps, level decision, backward walk.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state    <= ST_IDLE;
            start_q  <= '0;
            end_q    <= '0;
            mask_q   <= '0;
            visited  <= '0;
            snap     <= '0;
            level    <= '0;
            cnt      <= '0;
            added    <= 1'b0;
            cur      <= '0;
            found    <= 1'b0;
            path_len <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        start_q  <= start_node;
                        end_q    <= end_node;
                        mask_q   <= edge_mask;
                        found    <= 1'b0;
                        path_len <= '0;
                        state    <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    visited <= ONE_NODE << start_q;
                    snap    <= ONE_NODE << start_q;
                    level   <= '0;
                    cnt     <= '0;
                    added   <= 1'b0;
                    if (start_q == end_q) begin
                        found    <= 1'b1;
                        path_len <= '0;
                        state    <= ST_FIN;
                    end else begin
                        state <= ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    if (expand) begin
                        visited[far_node] <= 1'b1;
                        added             <= 1'b1;
                    end
                    if (cnt == CNT_LAST) begin
                        state <= ST_EVAL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_EVAL: begin
                    if (visited[end_q]) begin
                        cur   <= end_q;
                        state <= ST_BACK;
                    end else if (!added || (lvl_nx == LVL_MAX)) begin
                        found <= 1'b0;
                        state <= ST_FIN;
                    end else begin
                        level <= lvl_nx;
                        snap  <= visited;
                        cnt   <= '0;
                        added <= 1'b0;
                        state <= ST_SWEEP;
                    end
                end
                ST_BACK: begin
                    if (path_valid && path_ready) begin
                        cur <= par_node;
                        if (par_node == start_q) begin
                            found    <= 1'b1;
                            path_len <= lvl_nx;
                            state    <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_graph_bfs_path.sv
`default_nettype none
// ============================================================================
//  Module   : tb_graph_bfs_path
//  Purpose  : Self-checking bench: directed graphs plus random graphs, each
//             compared cycle by cycle against a sweep-level BFS model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_graph_bfs_path;

    localparam int N  = 8;
    localparam int E  = 16;
    localparam int ML = 4;
    localparam int NW = 3;
    localparam int EW = 4;
    localparam int LW = 3;

    logic          CLK = 1'b0;
    logic          RST_n = 1'b0;
    logic          start = 1'b0;
    logic [NW-1:0] start_node = '0;
    logic [NW-1:0] end_node = '0;
    logic [E-1:0]  edge_mask = '0;
    logic          edge_rd;
    logic [EW-1:0] edge_addr;
    logic [NW-1:0] edge_a = '0;
    logic [NW-1:0] edge_b = '0;
    logic          busy;
    logic          path_valid;
    logic          path_ready = 1'b1;
    logic [EW-1:0] path_edge;
    logic [NW-1:0] path_node;
    logic          done;
    logic          found;
    logic [LW-1:0] path_len;

    int vectors = 0;
    int miscompares = 0;

    logic [NW-1:0] tbl_a [E];
    logic [NW-1:0] tbl_b [E];
    logic [E-1:0]  mask = '0;

    int m_found;
    int m_len;
    int m_nsw;
    int m_pe[$];
    int m_pn[$];
    int done_lat;

    always #5 CLK = ~CLK;

    graph_bfs_path #(
        .NODES     (N),
        .EDGES     (E),
        .MAX_LEVEL (ML)
    ) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .start      (start),
        .start_node (start_node),
        .end_node   (end_node),
        .edge_mask  (edge_mask),
        .edge_rd    (edge_rd),
        .edge_addr  (edge_addr),
        .edge_a     (edge_a),
        .edge_b     (edge_b),
        .busy       (busy),
        .path_valid (path_valid),
        .path_ready (path_ready),
        .path_edge  (path_edge),
        .path_node  (path_node),
        .done       (done),
        .found      (found),
        .path_len   (path_len)
    );

    // Edge table memory: data appears the cycle after the read strobe.
    always @(posedge CLK) begin
        if (edge_rd) begin
            edge_a <= tbl_a[edge_addr];
            edge_b <= tbl_b[edge_addr];
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < E; i++) begin
            tbl_a[i] = NW'(7);
            tbl_b[i] = NW'(7);
        end
    endtask

    task automatic set_edge(input int i, input int a, input int b);
        tbl_a[i] = NW'(a);
        tbl_b[i] = NW'(b);
    endtask

    // Level-by-level BFS over the whole table; lowest edge index wins a node.
    task automatic model(input int s, input int e);
        logic [N-1:0] v;
        logic [N-1:0] fr;
        int pe [N];
        int pn [N];
        int lvl;
        int added;
        int cur;
        int guard;
        m_pe.delete();
        m_pn.delete();
        for (int k = 0; k < N; k++) begin
            pe[k] = 0;
            pn[k] = 0;
        end
        v = '0;
        v[s] = 1'b1;
        lvl = 0;
        m_nsw = 0;
        m_found = 0;
        m_len = 0;
        if (s == e) begin
            m_found = 1;
            return;
        end
        forever begin
            fr = v;
            added = 0;
            for (int i = 0; i < E; i++) begin
                int a;
                int b;
                int u;
                a = int'(tbl_a[i]);
                b = int'(tbl_b[i]);
                if (!mask[i] && a < N && b < N && fr[a] != fr[b]) begin
                    u = fr[a] ? b : a;
                    if (!v[u]) begin
                        v[u] = 1'b1;
                        pe[u] = i;
                        pn[u] = fr[a] ? a : b;
                        added = 1;
                    end
                end
            end
            m_nsw++;
            if (v[e]) begin
                m_found = 1;
                m_len = lvl + 1;
                break;
            end
            if (added == 0 || lvl + 1 == ML) break;
            lvl++;
        end
        if (m_found == 1) begin
            cur = e;
            guard = 0;
            while (cur != s && guard < N) begin
                m_pe.push_back(pe[cur]);
                m_pn.push_back(cur);
                cur = pn[cur];
                guard++;
            end
        end
    endtask

    // One search, checked every cycle. rmode: 0 ready=1, 1 pattern 1-0-0-1,
    // 2 random. poke re-asserts start with swapped endpoints while busy.
    task automatic run(input int s, input int e, input int rmode, input int poke);
        int n;
        int n_last;
        int bi;
        int p;
        int j;
        int fin_seen;
        model(s, e);
        n_last = 1 + m_nsw * (E + 2);
        @(negedge CLK);
        start = 1'b1;
        start_node = NW'(s);
        end_node = NW'(e);
        edge_mask = mask;
        path_ready = 1'b1;
        n = 0;
        bi = 0;
        p = 0;
        fin_seen = 0;
        while (fin_seen == 0 && n < 3000) begin
            @(negedge CLK);
            n++;
            start = 1'b0;
            if (poke != 0 && n == 4) begin
                start = 1'b1;
                start_node = NW'(e);
                end_node = NW'(s);
            end
            chk("busy", 32'(busy), 1);
            if (n <= n_last) begin
                chk("path_valid_idle", 32'(path_valid), 0);
                chk("done_early", 32'(done), 0);
                if (n == 1) begin
                    chk("edge_rd_init", 32'(edge_rd), 0);
                end else begin
                    j = (n - 2) % (E + 2);
                    if (j < E) begin
                        chk("edge_rd_sweep", 32'(edge_rd), 1);
                        chk("edge_addr", 32'(edge_addr), j);
                    end else if (j == E + 1) begin
                        chk("edge_rd_eval", 32'(edge_rd), 0);
                    end
                end
            end else if (bi < m_len) begin
                chk("edge_rd_back", 32'(edge_rd), 0);
                chk("done_back", 32'(done), 0);
                chk("path_valid", 32'(path_valid), 1);
                chk("path_edge", 32'(path_edge), m_pe[bi]);
                chk("path_node", 32'(path_node), m_pn[bi]);
            end else begin
                chk("done", 32'(done), 1);
                chk("found", 32'(found), m_found);
                chk("path_len", 32'(path_len), m_len);
                chk("path_valid_fin", 32'(path_valid), 0);
                fin_seen = 1;
                done_lat = n - 1;
            end
            if (n >= n_last) begin
                case (rmode)
                    1:       path_ready = ((p % 4) == 0 || (p % 4) == 3);
                    2:       path_ready = ($urandom_range(0, 1) == 1);
                    default: path_ready = 1'b1;
                endcase
                p++;
            end
            if (n > n_last && bi < m_len && path_ready) bi++;
        end
        if (fin_seen == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: no done after %0d cycles (expected one)", n);
            RST_n = 1'b0;
            repeat (2) @(negedge CLK);
            RST_n = 1'b1;
        end else begin
            @(negedge CLK);
            path_ready = 1'b1;
            chk("busy_after", 32'(busy), 0);
            chk("done_after", 32'(done), 0);
            chk("found_held", 32'(found), m_found);
            chk("path_len_held", 32'(path_len), m_len);
        end
    endtask

    initial begin
        clear_tbl();
        RST_n = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_edge_rd", 32'(edge_rd), 0);
        chk("rst_edge_addr", 32'(edge_addr), 0);
        chk("rst_path_valid", 32'(path_valid), 0);
        chk("rst_path_edge", 32'(path_edge), 0);
        chk("rst_path_node", 32'(path_node), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_found", 32'(found), 0);
        chk("rst_path_len", 32'(path_len), 0);
        RST_n = 1'b1;
        @(negedge CLK);

        // Three-edge chain 0-1-2-3.
        clear_tbl();
        set_edge(0, 0, 1);
        set_edge(1, 1, 2);
        set_edge(2, 2, 3);
        mask = '0;
        run(0, 3, 0, 0);
        chk("pin_chain_len", m_len, 3);
        chk("pin_chain_e0", m_pe[0], 2);
        chk("pin_chain_n0", m_pn[0], 3);
        chk("pin_chain_e2", m_pe[2], 0);
        chk("pin_chain_n2", m_pn[2], 1);

        // Shortcut edge 3-0, then masked off.
        set_edge(3, 3, 0);
        run(0, 3, 0, 0);
        chk("pin_short_len", m_len, 1);
        chk("pin_short_e0", m_pe[0], 3);
        chk("pin_short_n0", m_pn[0], 3);
        mask = 16'h0008;
        run(0, 3, 0, 0);
        chk("pin_masked_len", m_len, 3);
        mask = '0;

        // Unreachable target: search dies after two sweeps.
        clear_tbl();
        set_edge(0, 0, 1);
        run(0, 5, 0, 0);
        chk("pin_unreach_found", m_found, 0);
        chk("pin_unreach_nsw", m_nsw, 2);
        chk("done_latency", done_lat, 2 * (E + 2) + 1);

        // Five-edge chain exceeds the level limit.
        clear_tbl();
        for (int i = 0; i < 5; i++) set_edge(i, i, i + 1);
        run(0, 5, 0, 0);
        chk("pin_deep_found", m_found, 0);
        chk("pin_deep_nsw", m_nsw, ML);
        run(0, 4, 0, 0);
        chk("pin_maxlvl_len", m_len, ML);

        // Start equals end.
        run(6, 6, 0, 0);
        chk("pin_same_found", m_found, 1);
        chk("pin_same_beats", m_pe.size(), 0);
        chk("same_latency", done_lat, 1);

        // Chain with stalled stream and an ignored start while busy.
        clear_tbl();
        set_edge(0, 0, 1);
        set_edge(1, 1, 2);
        set_edge(2, 2, 3);
        run(0, 3, 1, 1);

        // Reset in the middle of a sweep.
        @(negedge CLK);
        start = 1'b1;
        start_node = NW'(0);
        end_node = NW'(3);
        @(negedge CLK);
        start = 1'b0;
        repeat (5) @(negedge CLK);
        chk("midsweep_rd", 32'(edge_rd), 1);
        RST_n = 1'b0;
        @(negedge CLK);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rd", 32'(edge_rd), 0);
        chk("abort_done", 32'(done), 0);
        repeat (3) begin
            @(negedge CLK);
            chk("abort_no_done", 32'(done), 0);
        end
        RST_n = 1'b1;
        run(0, 3, 0, 0);

        // Random graphs, masks, endpoints and back-pressure.
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < E; i++) begin
                set_edge(i, $urandom_range(0, N - 1), $urandom_range(0, N - 1));
                mask[i] = ($urandom_range(0, 7) == 0);
            end
            run($urandom_range(0, N - 1), $urandom_range(0, N - 1),
                $urandom_range(0, 2), $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
